vga_rx_decoder: RTL and testbench

Receive-side decoder for the VGA pixel stream generated by `vgac`. It sits on the `hs`/`vs`/`r`/`g`/`b` outputs and rebuilds pixel coordinates and pixel colour from the sync pulses. It also checks that line and frame timing are consistent and computes a per-frame checksum. Benches and on-board self-test use it to confirm composed frames without a monitor.

---
 rtl/vga_rx_decoder.sv | 165 ++++++++++++++++
 tb/tb_vga_rx_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_decoder.sv
// Receive-side VGA decoder: rebuilds pixel coordinates and colour from hs/vs,
// verifies line/frame timing and produces a rotating-XOR checksum per locked frame.
module vga_rx_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_BACK   = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_BACK   = 33,
  parameter int V_TOTAL  = 525
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_chk,
  output logic        locked,
  output logic        sync_error
);

  localparam logic [9:0]  HB = 10'(H_BACK);
  localparam logic [9:0]  HL = 10'(H_BACK + H_ACTIVE - 1);
  localparam logic [9:0]  VB = 10'(V_BACK);
  localparam logic [9:0]  VL = 10'(V_BACK + V_ACTIVE - 1);
  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [9:0]  VT = 10'(V_TOTAL);

  typedef enum logic [2:0] {SEARCH, SYNC, BACK, ACTIVE, FRONT} state_t;

  state_t      r_state;
  logic        r_hs_q, r_hs_p, r_vs_q, r_vs_p;
  logic [11:0] r_rgb_q;
  logic [9:0]  r_hcnt, r_vline, r_vlen;
  logic [10:0] r_hlen;
  logic        r_vpend, r_done_pend;
  logic [15:0] r_chk;

  logic        w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
  logic [9:0]  w_hcnt, w_vline, w_vlen;
  logic [10:0] w_hlen;
  logic        w_vpend_in, w_vpend, w_err, w_vis, w_last;
  logic [15:0] w_chk;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_hs_q  <= 1'b0;
      r_hs_p  <= 1'b0;
      r_vs_q  <= 1'b0;
      r_vs_p  <= 1'b0;
      r_rgb_q <= 12'h000;
    end else begin
      r_hs_q  <= hs;
      r_hs_p  <= r_hs_q;
      r_vs_q  <= vs;
      r_vs_p  <= r_vs_q;
      r_rgb_q <= {r, g, b};
    end
  end

  assign w_hs_rise = r_hs_q & ~r_hs_p;
  assign w_hs_fall = ~r_hs_q & r_hs_p;
  assign w_vs_rise = r_vs_q & ~r_vs_p;
  assign w_vs_fall = ~r_vs_q & r_vs_p;

  // w_* counter values describe the sample currently held in r_rgb_q, so the
  // visibility decision and the output register line up with the pixel data.
  always_comb begin
    w_hcnt = (r_hcnt == 10'h3FF) ? r_hcnt : r_hcnt + 10'd1;
    if (w_hs_rise) w_hcnt = 10'd0;
    w_vpend_in = r_vpend | w_vs_rise;
    w_vline    = r_vline;
    if (w_hs_rise) begin
      if (w_vpend_in)              w_vline = 10'd0;
      else if (r_vline != 10'h3FF) w_vline = r_vline + 10'd1;
    end
    w_vpend = w_vpend_in & ~w_hs_rise;
    w_hlen  = (r_hlen == 11'h7FF) ? r_hlen : r_hlen + 11'd1;
    w_vlen  = (w_hs_fall && r_vlen != 10'h3FF) ? r_vlen + 10'd1 : r_vlen;
    w_err   = (r_state != SEARCH) &&
              ((w_hs_fall && w_hlen != HT) || (w_vs_fall && w_vlen != VT));
    w_vis   = (r_state == ACTIVE) && (w_hcnt >= HB) && (w_hcnt <= HL) &&
              (w_vline >= VB) && (w_vline <= VL);
    w_last  = w_vis && (w_hcnt == HL) && (w_vline == VL);
    w_chk   = {r_chk[14:0], r_chk[15]} ^ {4'h0, r_rgb_q};
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= SEARCH;
      r_hcnt      <= 10'd0;
      r_vline     <= 10'd0;
      r_vlen      <= 10'd0;
      r_hlen      <= 11'd0;
      r_vpend     <= 1'b0;
      r_done_pend <= 1'b0;
      r_chk       <= 16'h0000;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 12'h000;
      frame_done  <= 1'b0;
      frame_chk   <= 16'h0000;
      locked      <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      r_hcnt     <= w_hcnt;
      r_vline    <= w_vline;
      r_vpend    <= w_vpend;
      r_hlen     <= w_hs_fall ? 11'd0 : w_hlen;
      r_vlen     <= w_vs_fall ? 10'd0 : w_vlen;
      sync_error <= w_err;

      pix_valid <= w_vis & locked;
      pix_x     <= (w_vis & locked) ? w_hcnt - HB : 10'd0;
      pix_y     <= (w_vis & locked) ? w_vline - VB : 10'd0;
      pix_rgb   <= (w_vis & locked) ? r_rgb_q : 12'h000;

      // frame_done trails the final pix_valid by one cycle; r_chk is stable then
      r_done_pend <= w_last & locked & ~w_err;
      frame_done  <= r_done_pend & ~w_err;
      if (r_done_pend && !w_err) frame_chk <= r_chk;

      if (w_err) begin
        r_state <= SEARCH;
        locked  <= 1'b0;
        r_chk   <= 16'h0000;
      end else begin
        case (r_state)
          SEARCH: if (w_vs_fall) r_state <= SYNC;
          SYNC: if (w_vs_rise) begin
            r_state <= BACK;
            r_chk   <= 16'h0000;
          end
          BACK: begin
            if (w_vs_fall) begin
              r_state <= SYNC;
              locked  <= 1'b0;
            end else if (!w_vpend && w_vline == VB) r_state <= ACTIVE;
          end
          ACTIVE: begin
            if (w_vis) r_chk <= w_chk;
            if (w_last) r_state <= FRONT;
            else if (w_vs_fall) begin
              r_state <= SYNC;
              locked  <= 1'b0;
            end
          end
          FRONT: if (w_vs_fall) begin
            r_state <= SYNC;
            locked  <= 1'b1;
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder with a shrunken raster: the bench plays the
// role of vgac and scores whole frames (pixel count, checksum, lock, errors).
module tb_vga_rx_decoder;

  localparam int HA = 8, HB = 3, HT = 20, VA = 4, VB = 2, VT = 10;
  localparam int HSW = 2, VSW = 2;

  logic        vga_clk, clrn, hs, vs;
  logic [3:0]  r, g, b;
  logic        pix_valid, frame_done, locked, sync_error;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_rgb;
  logic [15:0] frame_chk;

  vga_rx_decoder #(
    .H_ACTIVE(HA), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BACK(VB), .V_TOTAL(VT)
  ) dut (
    .vga_clk(vga_clk), .clrn(clrn), .hs(hs), .vs(vs),
    .r(r), .g(g), .b(b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_chk(frame_chk),
    .locked(locked), .sync_error(sync_error)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  int n_valid, n_done, n_serr, bad, last_x, last_y, org_lat, org_cyc;
  logic lock_start;
  logic [11:0] org_rgb;
  logic [15:0] done_chk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pat(input int mode, input int x, input int y);
    int t;
    logic [11:0] v;
    t = x ^ y;
    case (mode)
      1: v = (x == 0 && y == 0) ? 12'hFFF : 12'h000;
      2: v = {x[3:0], y[3:0], t[3:0]};
      default: v = 12'h000;
    endcase
    return v;
  endfunction

  function automatic logic [15:0] model_chk(input int mode);
    logic [15:0] c;
    c = 16'h0000;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        c = {c[14:0], c[15]} ^ {4'h0, pat(mode, x, y)};
    return c;
  endfunction

  task automatic step(input int mode);
    @(posedge vga_clk);
    #1;
    if (pix_valid) begin
      n_valid++;
      last_x = int'(pix_x);
      last_y = int'(pix_y);
      if (pix_rgb !== pat(mode, int'(pix_x), int'(pix_y))) bad++;
      if (pix_x == 10'd0 && pix_y == 10'd0) begin
        org_rgb = pix_rgb;
        org_lat = cyc - org_cyc;
      end
    end
    if (frame_done) begin
      n_done++;
      done_chk = frame_chk;
    end
    if (sync_error) n_serr++;
  endtask

  task automatic run_frame(input int mode, input int short_line, input int rst_line);
    int len, x, y;
    n_valid = 0; n_done = 0; n_serr = 0; bad = 0;
    last_x = -1; last_y = -1; org_lat = -1; org_cyc = 0;
    org_rgb = 12'h000; done_chk = 16'h0000; lock_start = 1'b0;
    for (int v = 0; v < VT; v++) begin
      len = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        x  = h - HSW - HB;
        y  = v - VSW - VB;
        hs = (h >= HSW);
        vs = (v >= VSW);
        clrn = !(v == rst_line && h < 3);
        if (x >= 0 && x < HA && y >= 0 && y < VA) begin
          {r, g, b} = pat(mode, x, y);
          if (x == 0 && y == 0) org_cyc = cyc;
        end else {r, g, b} = 12'h000;
        step(mode);
        if (v == 0 && h == 4) lock_start = locked;
        if (v == rst_line && h == 2)
          check("outs_in_reset",
                {pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_chk, locked, sync_error},
                64'd0);
      end
    end
  endtask

  initial begin
    clrn = 1'b0; hs = 1'b1; vs = 1'b1; {r, g, b} = 12'h000;
    repeat (3) @(posedge vga_clk);
    #1;
    check("rst_pix", {pix_valid, pix_x, pix_y, pix_rgb}, 64'd0);
    check("rst_done", {frame_done, frame_chk}, 64'd0);
    check("rst_locked", locked, 0);
    check("rst_serr", sync_error, 0);
    clrn = 1'b1;
    repeat (4) step(0);

    // frame 1: acquisition only
    run_frame(0, -1, -1);
    check("f1_lock_start", lock_start, 0);
    check("f1_valid", n_valid, 0);
    check("f1_done", n_done, 0);
    check("f1_serr", n_serr, 0);

    run_frame(0, -1, -1);
    check("f2_lock_start", lock_start, 1);
    check("f2_valid", n_valid, HA * VA);
    check("f2_done", n_done, 1);
    check("f2_chk", done_chk, 16'h0000);
    check("f2_last_xy", {last_x, last_y}, {32'(HA - 1), 32'(VA - 1)});
    check("f2_serr", n_serr, 0);

    run_frame(1, -1, -1);
    check("f3_org_rgb", org_rgb, 12'hFFF);
    check("f3_org_lat", org_lat, 2);
    check("f3_bad", bad, 0);
    check("f3_done", n_done, 1);
    check("f3_chk", done_chk, model_chk(1));

    run_frame(2, -1, -1);
    check("f4_valid", n_valid, HA * VA);
    check("f4_bad", bad, 0);
    check("f4_chk", done_chk, model_chk(2));

    // short line before the visible window
    run_frame(0, 3, -1);
    check("f5_serr", n_serr, 1);
    check("f5_valid", n_valid, 0);
    check("f5_done", n_done, 0);
    check("f5_locked_end", locked, 0);

    run_frame(0, -1, -1);
    check("f6_lock_start", lock_start, 0);
    check("f6_valid", n_valid, 0);
    check("f6_done", n_done, 0);
    check("f6_serr", n_serr, 0);

    run_frame(0, -1, -1);
    check("f7_lock_start", lock_start, 1);
    check("f7_valid", n_valid, HA * VA);
    check("f7_done", n_done, 1);

    // reset pulse in the middle of the visible area (line 5 = visible row 1)
    run_frame(2, -1, 5);
    check("f8_valid", n_valid, HA);
    check("f8_done", n_done, 0);
    check("f8_locked_end", locked, 0);

    run_frame(2, -1, -1);
    check("f9_lock_start", lock_start, 0);
    check("f9_valid", n_valid, 0);

    run_frame(2, -1, -1);
    check("f10_lock_start", lock_start, 1);
    check("f10_valid", n_valid, HA * VA);
    check("f10_chk", done_chk, model_chk(2));
    check("f10_serr", n_serr, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
